// File: rtl/stream_aligner.sv
// Packs variable-length input beats into full-width output words, with passthrough beats.
// Define STREAM_ALIGNER_CNT_EN to add the frame_cnt/byte_cnt transfer counters.
module stream_aligner #(
    parameter int DATA_OUT_WIDTH = 256,
    parameter int IN_BYTES       = 32,
    parameter int TAG_WIDTH      = 16,
    parameter int LEN_WIDTH      = 6
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [IN_BYTES*8+TAG_WIDTH-1:0]   in_data,
    input  logic [LEN_WIDTH-1:0]              in_len,
    input  logic                              in_last,
    input  logic                              in_compressed,
    input  logic                              in_is_header,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_OUT_WIDTH-1:0]         out_data,
    output logic [DATA_OUT_WIDTH/8-1:0]       out_keep,
    output logic                              out_last
`ifdef STREAM_ALIGNER_CNT_EN
    ,
    output logic [31:0]                       frame_cnt,
    output logic [31:0]                       byte_cnt
`endif
);

    localparam int OUT_BYTES = DATA_OUT_WIDTH / 8;
    localparam int ACC_BYTES = 2 * OUT_BYTES;
    localparam int FILL_W    = $clog2(ACC_BYTES + 1);
    localparam logic [FILL_W-1:0]    OUT_BYTES_F = FILL_W'(OUT_BYTES);
    localparam logic [LEN_WIDTH-1:0] IN_BYTES_L  = LEN_WIDTH'(IN_BYTES);

    typedef enum logic [1:0] {IDLE, PACK, FLUSH, DRAIN} state_t;

    state_t                      state, state_nxt;
    logic [FILL_W-1:0]           fill, fill_nxt;
    logic [ACC_BYTES*8-1:0]      acc, acc_nxt;
    logic [ACC_BYTES*8-1:0]      payload;
    logic [LEN_WIDTH-1:0]        len_c;
    logic [DATA_OUT_WIDTH-1:0]   pass_data, load_data;
    logic [OUT_BYTES-1:0]        part_keep, load_keep;
    logic                        load, load_last;
    logic                        is_packed, out_free, full, in_fire;

    always_comb begin
        is_packed = in_compressed && !in_is_header;
        out_free  = !out_valid || out_ready;
        full      = (fill >= OUT_BYTES_F);
        len_c     = (in_len > IN_BYTES_L) ? IN_BYTES_L : in_len;
        in_ready  = reset && (state == IDLE || state == PACK) && !full &&
                    (is_packed || (fill == '0 && out_free));
        in_fire   = in_valid && in_ready;

        payload = '0;
        for (int unsigned k = 0; k < IN_BYTES; k++) begin
            if (k < 32'(len_c)) payload[8*k +: 8] = in_data[8*k +: 8];
        end

        pass_data = '0;
        pass_data[IN_BYTES*8-1:0] = in_data[IN_BYTES*8+TAG_WIDTH-1:TAG_WIDTH];

        part_keep = '0;
        for (int unsigned b = 0; b < OUT_BYTES; b++) begin
            if (b < 32'(fill)) part_keep[b] = 1'b1;
        end
    end

    // Bytes above fill are always zero, so the low word of acc is already zero-padded.
    always_comb begin
        state_nxt = state;
        fill_nxt  = fill;
        acc_nxt   = acc;
        load      = 1'b0;
        load_data = acc[DATA_OUT_WIDTH-1:0];
        load_keep = '1;
        load_last = 1'b0;
        case (state)
            IDLE, PACK: begin
                if (full) begin
                    if (out_free) begin
                        load     = 1'b1;
                        acc_nxt  = acc >> DATA_OUT_WIDTH;
                        fill_nxt = fill - OUT_BYTES_F;
                    end
                end else if (in_fire) begin
                    if (is_packed) begin
                        acc_nxt  = acc | (payload << {fill, 3'b000});
                        fill_nxt = fill + FILL_W'(len_c);
                    end else begin
                        load      = 1'b1;
                        load_data = pass_data;
                        load_last = in_last;
                    end
                end
                if (in_fire && is_packed && in_last)
                    state_nxt = FLUSH;
                else if (in_valid && !is_packed && fill_nxt != '0)
                    state_nxt = DRAIN;
                else
                    state_nxt = (fill_nxt == '0) ? IDLE : PACK;
            end
            FLUSH: begin
                if (out_free) begin
                    load = 1'b1;
                    if (full) begin
                        load_last = (fill == OUT_BYTES_F);
                        acc_nxt   = acc >> DATA_OUT_WIDTH;
                        fill_nxt  = fill - OUT_BYTES_F;
                        state_nxt = (fill == OUT_BYTES_F) ? IDLE : FLUSH;
                    end else begin
                        load_keep = part_keep;
                        load_last = 1'b1;
                        acc_nxt   = '0;
                        fill_nxt  = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (fill == '0) begin
                    state_nxt = IDLE;
                end else if (out_free) begin
                    load = 1'b1;
                    if (full) begin
                        acc_nxt   = acc >> DATA_OUT_WIDTH;
                        fill_nxt  = fill - OUT_BYTES_F;
                        state_nxt = (fill == OUT_BYTES_F) ? IDLE : DRAIN;
                    end else begin
                        load_keep = part_keep;
                        acc_nxt   = '0;
                        fill_nxt  = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            fill      <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else begin
            state <= state_nxt;
            fill  <= fill_nxt;
            acc   <= acc_nxt;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
                out_keep  <= load_keep;
                out_last  <= load_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef STREAM_ALIGNER_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
            byte_cnt  <= '0;
        end else if (out_valid && out_ready) begin
            if (out_last) frame_cnt <= frame_cnt + 32'd1;
            byte_cnt <= byte_cnt + 32'($countones(out_keep));
        end
    end
`endif

endmodule
